// File: rtl/regfile_pkg.sv
// Shared widths and types for the scoreboarded register file.
package regfile_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 4;
    localparam int NUM_REGS_DEF = 15;
    localparam int NUM_RD_DEF   = 3;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: reserve on issue, clear on write-back,
// with an incrementally maintained busy count.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb0_en,
    input  logic [ADDR_W-1:0]   wb0_addr,
    input  logic                wb1_en,
    input  logic [ADDR_W-1:0]   wb1_addr,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     busy_cnt
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_v;
    logic [NUM_REGS-1:0] clr_v;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_next;
    logic [ADDR_W:0]     dec;
    logic                inc;

    // Out-of-range addresses match no index, so they fall away here.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_v[i] = rsv_en && (rsv_addr == ADDR_W'(i));
            clr_v[i] = (wb0_en && (wb0_addr == ADDR_W'(i)))
                    || (wb1_en && (wb1_addr == ADDR_W'(i)));
        end
    end

    always_comb begin
        busy_next = (busy_q & ~clr_v) | set_v;
        inc = |(set_v & ~busy_q);
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            dec = dec + (ADDR_W+1)'(busy_q[i] & clr_v[i] & ~set_v[i]);
        end
        cnt_next = cnt_q + {{ADDR_W{1'b0}}, inc} - dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_next;
            cnt_q  <= cnt_next;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;
endmodule

// File: rtl/scoreboard_regfile.sv
// Flip-flop register file with two write-back ports, same-cycle
// bypass on all read ports and a busy scoreboard.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wb0_en   (wb0_en),
        .wb0_addr (wb0_addr),
        .wb1_en   (wb1_en),
        .wb1_addr (wb1_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // The younger write-back lands last on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb1_en && (wb1_addr == ADDR_W'(i))) begin
                    regs[i] <= wb1_data;
                end else if (wb0_en && (wb0_addr == ADDR_W'(i))) begin
                    regs[i] <= wb0_data;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        a   = '0;
        d   = '0;
        b   = 1'b0;
        hit = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            a   = rd_addr[p*ADDR_W +: ADDR_W];
            d   = '0;
            b   = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (a == ADDR_W'(i)) begin
                    d   = regs[i];
                    b   = busy[i];
                    hit = 1'b1;
                end
            end
            // A value arriving this cycle is forwarded and not busy.
            if (hit && wb0_en && (wb0_addr == a)) begin
                d = wb0_data;
                b = 1'b0;
            end
            if (hit && wb1_en && (wb1_addr == a)) begin
                d = wb1_data;
                b = 1'b0;
            end
            rd_data[p*DATA_W +: DATA_W] = d;
            rd_busy[p] = b;
        end
    end
endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NUM_REGS, default 15, number of architectural registers; legal range 2..2**ADDR_W.
REQ-003 Parameter ADDR_W, default 4, register address width.
REQ-004 Parameter NUM_RD, default 3, number of read ports; legal range 1..4.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rd_addr  input  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NUM_RD*DATA_W  read data, packed the same way.
REQ-009 rd_busy  output  NUM_RD  per-port flag: the register addressed has an outstanding producer.
REQ-010 wb0_en, wb1_en  input  1 each  write-back enables; wb1 is the younger instruction.
REQ-011 wb0_addr, wb1_addr  input  ADDR_W each  write-back destinations.
REQ-012 wb0_data, wb1_data  input  DATA_W each  write-back values.
REQ-013 rsv_en  input  1  reserve request from issue.
REQ-014 rsv_addr  input  ADDR_W  register to mark busy.
REQ-015 busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-016 Register array and busy vector SHALL update only on the rising edge of clk.
REQ-017 Write: when wbN_en is high and wbN_addr < NUM_REGS, the register SHALL take wbN_data at the edge.
REQ-018 Dual-write collision (both enables, same address): wb1_data SHALL be stored.
REQ-019 Reads SHALL be combinational from addresses, with same-cycle bypass; read latency is zero.
REQ-020 Bypass priority for rd_data: wb1 match, then wb0 match, then stored value.
REQ-021 A read address >= NUM_REGS SHALL return all zeros with rd_busy 0.
REQ-022 A write or reserve to an address >= NUM_REGS SHALL be ignored with no side effect.
REQ-023 Reserve: rsv_en with valid rsv_addr SHALL set busy[rsv_addr] at the edge.
REQ-024 A valid write SHALL clear busy[addr] at the edge.
REQ-025 Reserve and write to the same address in one cycle: reserve wins; busy SHALL be 1 afterwards.
REQ-026 Reserve of an already-busy register SHALL leave it busy; there is no nesting count.
REQ-027 rd_busy[p] SHALL equal busy[rd_addr[p]] AND NOT (any valid write to that address this cycle); bypassed data is not busy.
REQ-028 busy_cnt SHALL be a registered counter tracking the popcount of the busy vector after each edge.
REQ-029 busy_cnt SHALL update incrementally: +1 on a set of a clear bit, -1 per cleared busy bit, net change applied in one edge.
REQ-030 busy_cnt SHALL never exceed NUM_REGS or underflow.

Reset
REQ-031 With rst high at an edge, register i SHALL load i (zero-extended or truncated to DATA_W).
REQ-032 With rst high at an edge, all busy bits SHALL clear and busy_cnt SHALL become 0.
REQ-033 rst SHALL override any concurrent write or reserve in the same cycle.
REQ-034 Assertion of rst mid-operation SHALL discard all pending reservations; no write is lost except the one in the reset cycle.
REQ-035 Outputs after reset: rd_data equals the address value per REQ-031; rd_busy is 0.

Structure
REQ-036 DATA_W, ADDR_W and NUM_REGS defaults, and the register-address typedef, SHALL live in the shared package regfile_pkg.
REQ-037 Busy vector, reserve/clear logic and busy_cnt SHALL form sub-module reg_scoreboard; the data array and bypass stay in the top.
REQ-038 No memory macro; the array SHALL be flip-flops.

Verification
REQ-039 Reset, then read r0..r14 on all ports -> rd_data = 0..14, rd_busy = 0, busy_cnt = 0.
REQ-040 wb0 r3 = 0xDEADBEEF while port 0 reads r3 -> same-cycle rd_data 0xDEADBEEF; next cycle stored value 0xDEADBEEF.
REQ-041 wb0 r5 = 0x11 and wb1 r5 = 0x22 together -> bypass and stored value 0x22.
REQ-042 Reserve r7 -> rd_busy 1, busy_cnt 1; reserve r7 and wb r7 = 0x55 in the same cycle -> busy stays 1, r7 = 0x55; wb r7 alone -> busy 0, busy_cnt 0.
REQ-043 Reserve r1, r2, r4 on consecutive cycles, then rst -> busy_cnt 3 before reset, 0 after, r1 = 1.
REQ-044 Write and read address 15 with NUM_REGS = 15 -> rd_data 0, no register changes, busy_cnt unchanged.
